tt_pin_reg_responder: RTL and testbench

- Design-side responder for the byte-wide strobed register-access protocol the cocotb bench drives over the Tiny Tapeout pins.
- The host presents bytes on ui_in and uses a 4-phase strobe/ack handshake on uio[0]/uio[1].
- The block decodes read and write commands into a small register file, which it exposes to the design core.
- It sits directly under tt_um_* between the pin wrapper and the core logic.

---
 rtl/tt_pin_reg_pkg.sv | 17 +
 rtl/tt_pin_sync_edge.sv | 38 +++
 rtl/tt_pin_reg_responder.sv | 134 +++++++++++++
 tb/tb_tt_pin_reg_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_reg_pkg.sv
// Shared types and constants for the Tiny Tapeout pin-level register responder.
// Covers the FSM state encoding and the command byte field layout.
package tt_pin_reg_pkg;

    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned ADDR_W       = 7;
    localparam logic [7:0]  READ_BAD_VAL = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StRAck,
        StCAck,
        StWWait,
        StWAck
    } state_e;

endpackage

// File: rtl/tt_pin_sync_edge.sv
// Multi-stage synchronizer for an asynchronous strobe with a trailing edge-detect flop.
// Outputs the synchronized level and single-cycle rise/fall pulses.
module tt_pin_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        level_o = sync_q[SYNC_STAGES-1];
        rise_o  = level_o & ~prev_q;
        fall_o  = ~level_o & prev_q;
    end

endmodule

// File: rtl/tt_pin_reg_responder.sv
// Byte-wide strobed register-access responder: decodes host read/write commands
// arriving over a 4-phase strobe/ack handshake into a small register file.
module tt_pin_reg_responder #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [7:0]            data_in,
    input  logic                  strb_in,
    output logic [7:0]            data_out,
    output logic                  ack_out,
    output logic                  err_out,
    output logic [NUM_REGS*8-1:0] regs_flat
);

    import tt_pin_reg_pkg::*;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];

    logic              strb_rise, strb_fall;
    logic              unused_strb_level;
    logic [ADDR_W-1:0] in_addr, cmd_addr;
    logic              in_addr_valid;
    logic [7:0]        rd_val;

    tt_pin_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .async_i(strb_in),
        .level_o(unused_strb_level),
        .rise_o (strb_rise),
        .fall_o (strb_fall)
    );

    // Out-of-range addresses match no entry, so they read back as READ_BAD_VAL.
    always_comb begin
        in_addr       = data_in[ADDR_W-1:0];
        cmd_addr      = cmd_q[ADDR_W-1:0];
        in_addr_valid = 32'(in_addr) < NUM_REGS;
        rd_val        = READ_BAD_VAL;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (in_addr == ADDR_W'(i)) rd_val = regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (strb_rise) state_d = data_in[CMD_WR_BIT] ? StCAck : StRAck;
                StRAck:  if (strb_fall) state_d = StIdle;
                StCAck:  if (strb_fall) state_d = StWWait;
                StWWait: if (strb_rise) state_d = StWAck;
                StWAck:  if (strb_fall) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cmd_d      = cmd_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        regs_d     = regs_q;
        ack_d      = ena && (state_q inside {StRAck, StCAck, StWAck});
        if (ena) begin
            case (state_q)
                StIdle: begin
                    if (strb_rise) begin
                        cmd_d = data_in;
                        if (!data_in[CMD_WR_BIT]) data_out_d = rd_val;
                        if (!in_addr_valid)       err_d      = 1'b1;
                    end
                end
                StWWait: if (strb_rise) wdata_d = data_in;
                StWAck: begin
                    // Commit on the edge that raises ack so regs_flat and ack change together.
                    if (!ack_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (cmd_addr == ADDR_W'(i)) regs_d[i] = wdata_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign data_out = data_out_q;
    assign ack_out  = ack_q;
    assign err_out  = err_q;

endmodule

// File: tb/tb_tt_pin_reg_responder.sv
// Directed plus randomized bench for tt_pin_reg_responder, checked against
// an array-based model of the register file and the sticky error flag.
module tb_tt_pin_reg_responder;

    localparam int NREGS = 8;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [7:0]       data_in;
    logic             strb_in;
    logic [7:0]       data_out;
    logic             ack_out;
    logic             err_out;
    logic [NREGS*8-1:0] regs_flat;

    tt_pin_reg_responder #(
        .NUM_REGS   (NREGS),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .data_in  (data_in),
        .strb_in  (strb_in),
        .data_out (data_out),
        .ack_out  (ack_out),
        .err_out  (err_out),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_regs [NREGS];
    logic       model_err;
    logic [7:0] seen_dout;
    logic [63:0] seen_regs;
    int         lat_r, lat_f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model_regs[i];
        return f;
    endfunction

    // One full 4-phase handshake; latencies counted in clk cycles from the strobe edge.
    task automatic send_byte(input logic [7:0] b);
        data_in = b;
        strb_in = 1'b1;
        lat_r   = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack_out === 1'b1) begin
                lat_r = n;
                break;
            end
        end
        seen_dout = data_out;
        seen_regs = regs_flat;
        check("ack_rise_lat", 64'(lat_r), 64'(LAT));
        strb_in = 1'b0;
        lat_f   = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack_out === 1'b0) begin
                lat_f = n;
                break;
            end
        end
        check("ack_fall_lat", 64'(lat_f), 64'(LAT));
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] val);
        send_byte({1'b1, addr});
        send_byte(val);
        if (int'(addr) < NREGS) model_regs[addr[2:0]] = val;
        else                    model_err = 1'b1;
        check("wr_regs", seen_regs, model_flat());
        check("wr_err", 64'(err_out), 64'(model_err));
    endtask

    task automatic do_read(input logic [6:0] addr);
        logic [7:0] exp;
        exp = (int'(addr) < NREGS) ? model_regs[addr[2:0]] : 8'h00;
        if (int'(addr) >= NREGS) model_err = 1'b1;
        send_byte({1'b0, addr});
        check("rd_data", 64'(seen_dout), 64'(exp));
        check("rd_hold", 64'(data_out), 64'(exp));
        check("rd_err", 64'(err_out), 64'(model_err));
    endtask

    initial begin
        int acks;
        rst     = 1'b1;
        ena     = 1'b1;
        strb_in = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
        model_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_dout", 64'(data_out), 64'h0);
        check("rst_ack", 64'(ack_out), 64'h0);
        check("rst_err", 64'(err_out), 64'h0);
        check("rst_regs", regs_flat, 64'h0);

        // Write then read back reg3
        do_write(7'd3, 8'hA5);
        check("reg3", 64'(regs_flat[31:24]), 64'hA5);
        do_read(7'd3);

        // Bad address write and read
        do_write(7'h0A, 8'h55);
        check("bad_err", 64'(err_out), 64'h1);
        do_read(7'h0A);

        // Randomized mix, including out-of-range addresses
        repeat (24) begin
            logic [6:0] a;
            a = 7'($urandom_range(0, 11));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else                           do_read(a);
        end

        // Reset arriving together with the data strobe in W_WAIT
        send_byte(8'h81);
        @(negedge clk);
        data_in = 8'h77;
        strb_in = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        strb_in = 1'b0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
        model_err = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_out !== 1'b0) acks++;
        end
        check("rstmid_acks", 64'(acks), 64'h0);
        check("rstmid_regs", regs_flat, 64'h0);
        check("rstmid_err", 64'(err_out), 64'h0);
        do_write(7'd1, 8'h22);
        check("reg1", 64'(regs_flat[15:8]), 64'h22);

        // ena dropped while in C_ACK
        data_in = 8'h82;
        strb_in = 1'b1;
        lat_r   = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack_out === 1'b1) begin
                lat_r = n;
                break;
            end
        end
        check("ena_cmd_lat", 64'(lat_r), 64'(LAT));
        ena = 1'b0;
        @(negedge clk);
        check("ena_abort_ack", 64'(ack_out), 64'h0);
        ena  = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_out !== 1'b0) acks++;
        end
        check("ena_return_acks", 64'(acks), 64'h0);
        strb_in = 1'b0;
        repeat (6) @(negedge clk);
        check("ena_idle_ack", 64'(ack_out), 64'h0);
        check("ena_regs", regs_flat, model_flat());
        do_write(7'd2, 8'h3C);
        check("reg2", 64'(regs_flat[23:16]), 64'h3C);

        // Back-to-back writes then reads
        for (int i = 0; i < NREGS; i++) do_write(7'(i), 8'(8'h10 + i));
        for (int i = 0; i < NREGS; i++) do_read(7'(i));
        check("b2b_flat", regs_flat, 64'h1716151413121110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
